rom_read_arbiter: RTL and testbench
===================================

Name: rom_read_arbiter

Overview:
Shares one synchronous lookup ROM (ROM_BUCUR_S-style: registered read, 1-cycle latency) between two independent requesters. Each requester presents an address with a request. The arbiter grants one requester per cycle, drives the ROM address, tracks which requester owns each in-flight read, and returns the ROM word with a per-requester valid strobe. It sits between the ROM and the lab's control FSMs, for example a password-check FSM and a display sequencer.

Parameters:
ADDR_W, 2, ROM address width.
DATA_W, 4, ROM data width.
ROM_LAT, 1, ROM read latency in clock cycles from address sample to data valid; legal range 1..3.

Ports:
CLK  in  1  system clock, rising edge.
RST  in  1  asynchronous, active-high reset.
prio_fixed  in  1  0 = round-robin arbitration; 1 = fixed priority, requester 0 wins.
req0  in  1  requester 0 read request (level).
addr0  in  ADDR_W  requester 0 address; held stable while req0 is high.
req1  in  1  requester 1 read request (level).
addr1  in  ADDR_W  requester 1 address; held stable while req1 is high.
gnt0  out  1  one-cycle grant pulse to requester 0.
gnt1  out  1  one-cycle grant pulse to requester 1.
rvalid0  out  1  rdata belongs to requester 0 this cycle.
rvalid1  out  1  rdata belongs to requester 1 this cycle.
rdata  out  DATA_W  ROM word, combinational pass-through of rom_data.
rom_addr  out  ADDR_W  registered address to the ROM.
rom_data  in  DATA_W  ROM read data.

Behaviour:
- Reset (async, RST=1): gnt0, gnt1, rvalid0 and rvalid1 = 0; rom_addr = 0. The round-robin pointer last = 1, so requester 0 wins the first tie. The in-flight owner pipeline is cleared.
- Reset mid-read: any read in flight is dropped, and no rvalid asserts after RST deasserts for reads granted before reset.
- Eligibility at each rising edge: reqN is eligible only if reqN=1 and gntN=0 in the current cycle.
  - A requester that holds req through its grant cycle therefore gets no back-to-back grant.
  - A requester that deasserts req at the edge ending its grant cycle gets exactly one read.
- Decision at the edge:
  - Neither eligible: gnt0 = gnt1 = 0 next cycle; rom_addr holds its value; last is unchanged.
  - One eligible: grant it.
  - Both eligible, prio_fixed=1: grant 0.
  - Both eligible, prio_fixed=0: grant the requester that is not last.
  - On any grant, last is set to the granted index. last is updated in both priority modes.
- Grant cycle: the gntN registered pulse is high for exactly one cycle, rom_addr = addrN (registered at the same edge), and owner {valid, id} enters an owner shift register of depth ROM_LAT.
- Return: rvalidN = 1 exactly ROM_LAT cycles after the gntN cycle. For ROM_LAT=1 this is the cycle immediately after gntN. rdata = rom_data at all times; rvalid0 and rvalid1 are never high together.
- Throughput: one grant per cycle overall. With both requesters continuously requesting, grants alternate 0,1,0,1 in either mode, because the eligibility rule blocks consecutive grants to the same requester.
- Latency: 1 cycle from the sampling edge to gnt, and 1+ROM_LAT cycles from the sampling edge to rvalid.
- prio_fixed may change at any time; it takes effect at the next decision edge.
- Address change while req is high and no grant has been given: the address sampled on the grant edge is used.

Test Plan:
- ROM model contents 0→4'hA, 1→4'h5, 2→4'h3, 3→4'hC.
  1. Single read: assert RST for 2 cycles, release, then pulse req0 with addr0=2 → gnt0 high 1 cycle later with rom_addr=2; next cycle rvalid0=1, rdata=4'h3, rvalid1=0.
  2. Simultaneous, round-robin: after reset, req0=1/addr0=1 and req1=1/addr1=3 on the same edge, both held 4 cycles → grants 0,1,0,1. rvalid sequence 0,1,0,1 with rdata 4'h5, 4'hC, 4'h5, 4'hC.
  3. Fixed priority: prio_fixed=1, both request, each drops req after its grant → gnt0 first (data 4'h5), then gnt1 (data 4'hC). Repeat with prio_fixed=0 immediately after a grant to 0 → requester 1 wins the tie.
  4. Held request: req0 held high 6 cycles, req1=0, addr0=0 → gnt0 high every other cycle (3 grants); three rvalid0 pulses with rdata=4'hA; no gnt1 or rvalid1.
  5. Reset mid-read: assert RST in the gnt0 cycle of a read to addr 3 → outputs go to 0 asynchronously and no rvalid0 follows. The first post-reset tie goes to requester 0.
  6. ROM_LAT=2 build, using a 2-cycle ROM model: single read to addr 1 → rvalid1 two cycles after gnt1 with rdata=4'h5. Interleaved grants keep the owner order correct.

Source files
------------

// File: rtl/rom_read_arbiter.sv
// Two-port read arbiter in front of a single registered-read ROM.
// Grants one requester per cycle and tags returning data with the owner's valid strobe.
module rom_read_arbiter #(
  parameter int ADDR_W  = 2,
  parameter int DATA_W  = 4,
  parameter int ROM_LAT = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              prio_fixed,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data
);

  logic              gnt0_q, gnt0_d;
  logic              gnt1_q, gnt1_d;
  logic              last_q, last_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              elig0, elig1;

  // Owner pipeline: bit k describes the read that will return ROM_LAT-1-k cycles from now.
  logic [ROM_LAT-1:0] own_vld_q;
  logic [ROM_LAT-1:0] own_id_q;

  always_comb begin
    elig0      = req0 & ~gnt0_q;
    elig1      = req1 & ~gnt1_q;
    // Requester 0 wins a tie under fixed priority, or when it was not the last one served.
    gnt0_d     = elig0 & (~elig1 | prio_fixed | last_q);
    gnt1_d     = elig1 & ~gnt0_d;
    last_d     = last_q;
    rom_addr_d = rom_addr_q;
    if (gnt0_d) begin
      last_d     = 1'b0;
      rom_addr_d = addr0;
    end else if (gnt1_d) begin
      last_d     = 1'b1;
      rom_addr_d = addr1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      last_q       <= 1'b1;
      rom_addr_q   <= '0;
      own_vld_q[0] <= 1'b0;
      own_id_q[0]  <= 1'b0;
    end else begin
      gnt0_q       <= gnt0_d;
      gnt1_q       <= gnt1_d;
      last_q       <= last_d;
      rom_addr_q   <= rom_addr_d;
      own_vld_q[0] <= gnt0_q | gnt1_q;
      own_id_q[0]  <= gnt1_q;
    end
  end

  genvar gi;
  generate
    for (gi = 1; gi < ROM_LAT; gi++) begin : g_own_stage
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          own_vld_q[gi] <= 1'b0;
          own_id_q[gi]  <= 1'b0;
        end else begin
          own_vld_q[gi] <= own_vld_q[gi-1];
          own_id_q[gi]  <= own_id_q[gi-1];
        end
      end
    end
  endgenerate

  assign gnt0     = gnt0_q;
  assign gnt1     = gnt1_q;
  assign rom_addr = rom_addr_q;
  assign rdata    = rom_data;
  assign rvalid0  = own_vld_q[ROM_LAT-1] & ~own_id_q[ROM_LAT-1];
  assign rvalid1  = own_vld_q[ROM_LAT-1] &  own_id_q[ROM_LAT-1];

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Bench for rom_read_arbiter: a 1-cycle and a 2-cycle ROM build driven by the same stimulus,
// both checked against a cycle-level behavioural model of the grant/return rules.
module tb_rom_read_arbiter;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       prio_fixed = 1'b0;
  logic       req0 = 1'b0;
  logic       req1 = 1'b0;
  logic [1:0] addr0 = 2'd0;
  logic [1:0] addr1 = 2'd0;

  always #5 CLK = ~CLK;

  logic       ga0, ga1, va0, va1, gb0, gb1, vb0, vb1;
  logic [3:0] rda, rdb, romd_a, romd_b, romb_s1;
  logic [1:0] raa, rab;

  logic [3:0] rom_tbl [4] = '{4'hA, 4'h5, 4'h3, 4'hC};

  always @(posedge CLK) romd_a <= rom_tbl[raa];
  always @(posedge CLK) begin
    romb_s1 <= rom_tbl[rab];
    romd_b  <= romb_s1;
  end

  rom_read_arbiter #(.ADDR_W(2), .DATA_W(4), .ROM_LAT(1)) u_dut_l1 (
    .CLK(CLK), .RST(RST), .prio_fixed(prio_fixed),
    .req0(req0), .addr0(addr0), .req1(req1), .addr1(addr1),
    .gnt0(ga0), .gnt1(ga1), .rvalid0(va0), .rvalid1(va1),
    .rdata(rda), .rom_addr(raa), .rom_data(romd_a)
  );

  rom_read_arbiter #(.ADDR_W(2), .DATA_W(4), .ROM_LAT(2)) u_dut_l2 (
    .CLK(CLK), .RST(RST), .prio_fixed(prio_fixed),
    .req0(req0), .addr0(addr0), .req1(req1), .addr1(addr1),
    .gnt0(gb0), .gnt1(gb1), .rvalid0(vb0), .rvalid1(vb1),
    .rdata(rdb), .rom_addr(rab), .rom_data(romd_b)
  );

  int checks = 0;
  int failures = 0;

  // Model state: index of the requester granted this cycle (-1 none), last winner,
  // current ROM address, and a short history of grants/addresses (index 0 = this cycle).
  int         m_gnt;
  int         m_last;
  logic [1:0] m_addr;
  int         g_hist [4];
  logic [1:0] a_hist [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_gnt  = -1;
    m_last = 1;
    m_addr = 2'd0;
    for (int i = 0; i < 4; i++) begin
      g_hist[i] = -1;
      a_hist[i] = 2'd0;
    end
  endfunction

  function automatic void model_edge();
    bit e0, e1;
    int w;
    for (int i = 3; i > 0; i--) begin
      g_hist[i] = g_hist[i-1];
      a_hist[i] = a_hist[i-1];
    end
    e0 = req0 && (m_gnt != 0);
    e1 = req1 && (m_gnt != 1);
    if (e0 && e1)  w = prio_fixed ? 0 : ((m_last == 0) ? 1 : 0);
    else if (e0)   w = 0;
    else if (e1)   w = 1;
    else           w = -1;
    if (w >= 0) begin
      m_last = w;
      m_addr = (w == 0) ? addr0 : addr1;
    end
    m_gnt     = w;
    g_hist[0] = w;
    a_hist[0] = m_addr;
  endfunction

  task automatic check_all();
    chk("gnt0_l1", ga0, m_gnt == 0);
    chk("gnt1_l1", ga1, m_gnt == 1);
    chk("gnt0_l2", gb0, m_gnt == 0);
    chk("gnt1_l2", gb1, m_gnt == 1);
    chk("rom_addr_l1", raa, m_addr);
    chk("rom_addr_l2", rab, m_addr);
    chk("rvalid0_l1", va0, g_hist[1] == 0);
    chk("rvalid1_l1", va1, g_hist[1] == 1);
    chk("rvalid0_l2", vb0, g_hist[2] == 0);
    chk("rvalid1_l2", vb1, g_hist[2] == 1);
    if (g_hist[1] >= 0) chk("rdata_l1", rda, rom_tbl[a_hist[1]]);
    if (g_hist[2] >= 0) chk("rdata_l2", rdb, rom_tbl[a_hist[2]]);
  endtask

  // Inputs are set at the falling edge; the model steps at the rising edge and
  // outputs are compared at the following falling edge.
  task automatic tick();
    @(posedge CLK);
    if (RST) model_reset();
    else     model_edge();
    @(negedge CLK);
    check_all();
  endtask

  initial begin
    model_reset();
    @(negedge CLK);
    check_all();
    tick();
    tick();
    RST = 1'b0;

    // Single read to address 2.
    req0 = 1'b1; addr0 = 2'd2;
    tick();
    chk("t1_gnt0", ga0, 1);
    chk("t1_rom_addr", raa, 2);
    req0 = 1'b0;
    tick();
    chk("t1_rvalid0", va0, 1);
    chk("t1_rdata", rda, 4'h3);
    chk("t1_rvalid1", va1, 0);
    tick();
    chk("t1_rvalid0_l2", vb0, 1);
    chk("t1_rdata_l2", rdb, 4'h3);
    tick();

    // Simultaneous round-robin requests held for 4 cycles.
    RST = 1'b1; tick(); RST = 1'b0;
    req0 = 1'b1; addr0 = 2'd1; req1 = 1'b1; addr1 = 2'd3;
    tick(); chk("t2_g0", ga0, 1);
    tick(); chk("t2_g1", ga1, 1); chk("t2_d0", rda, 4'h5);
    tick(); chk("t2_g2", ga0, 1); chk("t2_d1", rda, 4'hC);
    tick(); chk("t2_g3", ga1, 1);
    req0 = 1'b0; req1 = 1'b0;
    repeat (3) tick();

    // Fixed priority, then switch to round-robin right after a grant to 0.
    prio_fixed = 1'b1; req0 = 1'b1; req1 = 1'b1;
    tick(); chk("t3_fixed_g0", ga0, 1);
    req0 = 1'b0;
    tick(); chk("t3_fixed_g1", ga1, 1); chk("t3_fixed_d0", rda, 4'h5);
    req1 = 1'b0;
    tick(); chk("t3_fixed_d1", rda, 4'hC);
    tick();
    req0 = 1'b1; req1 = 1'b1;
    tick();
    prio_fixed = 1'b0;
    req0 = 1'b0;
    tick();
    req0 = 1'b1;
    tick();
    req0 = 1'b0; req1 = 1'b0;
    repeat (3) tick();

    // Held request from requester 0 only.
    addr0 = 2'd0; req0 = 1'b1;
    repeat (6) tick();
    req0 = 1'b0;
    repeat (3) tick();

    // Reset in the grant cycle of a read to address 3.
    addr0 = 2'd3; req0 = 1'b1;
    tick();
    chk("t5_gnt0_before", ga0, 1);
    RST = 1'b1;
    #1;
    model_reset();
    check_all();
    req0 = 1'b0;
    @(negedge CLK);
    tick();
    RST = 1'b0;
    tick();
    tick();
    req0 = 1'b1; req1 = 1'b1; addr1 = 2'd2;
    tick();
    chk("t5_first_tie", ga0, 1);
    req0 = 1'b0; req1 = 1'b0;
    repeat (4) tick();

    // Randomized traffic with occasional resets and priority changes.
    for (int n = 0; n < 400; n++) begin
      req0       = 1'($urandom_range(0, 1));
      req1       = 1'($urandom_range(0, 1));
      addr0      = 2'($urandom_range(0, 3));
      addr1      = 2'($urandom_range(0, 3));
      prio_fixed = ($urandom_range(0, 7) == 0) ? ~prio_fixed : prio_fixed;
      RST        = ($urandom_range(0, 49) == 0);
      if (RST) begin
        #1;
        model_reset();
        check_all();
      end
      tick();
      RST = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
